// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and the default busy-cycle counts.
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is formed
// at accept time, parked in a pending register, and committed after a fixed latency.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        rdSel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? (~a + 32'd1) : a;
    mb = b[31] ? (~b + 32'd1) : b;
    q  = 32'd0;
    r  = 32'd0;
    if (mb != 32'd0) begin
      q = ma / mb;
      r = ma % mb;
    end
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    q = 32'd0;
    r = 32'd0;
    if (b != 32'd0) begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_load;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_pend;
  logic [63:0]        w_pend_nxt;
  logic               r_nowr;
  logic               w_nowr_nxt;
  logic               w_accept;
  logic               w_commit;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic signed [63:0] w_a_s;
  logic signed [63:0] w_b_s;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;

  assign w_a_s    = {{32{inA[31]}}, inA};
  assign w_b_s    = {{32{inB[31]}}, inB};
  assign w_prod_s = w_a_s * w_b_s;
  assign w_prod_u = {32'd0, inA} * {32'd0, inB};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    w_cnt_load  = '0;
    w_pend_nxt  = 64'd0;
    w_nowr_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (mdOp)
            OP_MULT, OP_MULTU: begin
              w_accept    = 1'b1;
              w_cnt_load  = CNT_W'(MULT_CYCLES);
              w_pend_nxt  = (mdOp == OP_MULT) ? w_prod_s : w_prod_u;
              w_state_nxt = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              w_accept    = 1'b1;
              w_cnt_load  = CNT_W'(DIV_CYCLES);
              w_pend_nxt  = (mdOp == OP_DIV) ? div_signed(inA, inB) : div_unsigned(inA, inB);
              w_nowr_nxt  = (inB == 32'd0);
              w_state_nxt = ST_DIV;
            end
            OP_MTHI: w_wr_hi = 1'b1;
            OP_MTLO: w_wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_pend  <= 64'd0;
      r_nowr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= w_cnt_load;
        r_busy <= 1'b1;
        r_pend <= w_pend_nxt;
        r_nowr <= w_nowr_nxt;
      end else if (r_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_commit) r_busy <= 1'b0;
      end
    end
  end

  // A divide by zero runs the full latency but suppresses the HI/LO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_nowr) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else begin
      if (w_wr_hi) r_hi <= inA;
      if (w_wr_lo) r_lo <= inA;
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign mdOut = rdSel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: stimulus pushes expected HI/LO and busy length into a queue;
// a negedge monitor pops and compares each time busy falls.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdOp = OP_NONE;
  logic [31:0] inA = 32'd0;
  logic [31:0] inB = 32'd0;
  logic        rdSel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdOut;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          e_cyc;
  } exp_t;

  exp_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp), .inA(inA), .inB(inB),
    .rdSel(rdSel), .busy(busy), .hi(hi), .lo(lo), .mdOut(mdOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks the committed result when busy falls.
  int  mon_cyc = 0;
  bit  mon_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      mon_cyc  = 0;
      mon_prev = 1'b0;
    end else begin
      if (busy) mon_cyc++;
      else if (mon_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: got hi=0x%08h lo=0x%08h expected no commit", hi, lo);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, hi, e.e_hi);
          chk({e.name, "_lo"}, lo, e.e_lo);
          chk({e.name, "_busy_cycles"}, 32'(mon_cyc), 32'(e.e_cyc));
          chk({e.name, "_mdOut"}, mdOut, rdSel ? e.e_hi : e.e_lo);
        end
        mon_cyc = 0;
      end
      mon_prev = busy;
    end
  end

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.name = name; e.e_hi = h; e.e_lo = l; e.e_cyc = c;
    sb.push_back(e);
  endtask

  // Presents one request for exactly one rising edge, then scrambles the operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; mdOp = op; inA = a; inB = b;
    @(posedge clk); #1;
    start = 1'b0; mdOp = OP_NONE; inA = $urandom; inB = $urandom;
    rdSel = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: busy still 1 expected 0 within 50 cycles", name);
    end
  endtask

  initial begin
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rdSel = 1'b1;
    chk("reset_mdOut", mdOut, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // mult -2 * 3, operands scrambled after accept; HI/LO must hold while busy
    push("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy_up", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("mult_hold_hi", hi, 32'd0);
    chk("mult_hold_lo", lo, 32'd0);
    wait_idle("mult");

    push("multu", 32'hFFFFFFFE, 32'h00000001, 5);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu");

    push("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg");

    push("div_ovf", 32'h00000000, 32'h80000000, 10);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    push("divu", 32'd2, 32'd14, 10);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle("divu");

    // mthi/mtlo write in one edge without raising busy
    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(OP_MTLO, 32'h5678, 32'd0);
    chk("mtlo_lo", lo, 32'h5678);
    issue(3'b111, 32'hDEAD, 32'hBEEF);
    chk("reserved_hi", hi, 32'h1234);
    chk("reserved_lo", lo, 32'h5678);

    push("divu_zero", 32'h1234, 32'h5678, 10);
    issue(OP_DIVU, 32'h99, 32'd0);
    wait_idle("divu_zero");

    // mtlo while a mult is in flight is ignored
    push("mult_busy_mtlo", 32'd0, 32'd12, 5);
    issue(OP_MULT, 32'd3, 32'd4);
    issue(OP_MTLO, 32'hAAAA, 32'd0);
    wait_idle("mult_busy_mtlo");

    // start held through the commit edge: ignored there, accepted on the next edge
    push("mult_b2b", 32'd0, 32'd4, 5);
    issue(OP_MULT, 32'd2, 32'd2);
    start = 1'b1; mdOp = OP_MTHI; inA = 32'hBEEF;
    wait_idle("mult_b2b");
    chk("b2b_commit_hi", hi, 32'd0);
    @(posedge clk); #1;
    chk("b2b_accept_hi", hi, 32'hBEEF);
    start = 1'b0; mdOp = OP_NONE;

    // reset in the middle of a div: immediate clear, no later commit
    issue(OP_DIV, 32'd100, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rdSel = 1'b1;
    #1;
    chk("rst_mdOut_hi", mdOut, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    push("after_reset", 32'd0, 32'd42, 5);
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_idle("after_reset");
    repeat (2) @(posedge clk);

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for mult/multu.
REQ-002 The module SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for div/divu.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 reset  input  1  Reset, asynchronous and active-low; the unit is in reset while reset==0.
REQ-005 start  input  1  Qualifies mdOp for one cycle.
REQ-006 mdOp  input  3  Operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 reserved and treated as none.
REQ-007 inA  input  32  Operand A (rs), the same value presented to the ALU.
REQ-008 inB  input  32  Operand B (rt), the same value presented to the ALU.
REQ-009 rdSel  input  1  Selects mdOut: 0 gives LO, 1 gives HI.
REQ-010 busy  output  1  High while an operation is in flight.
REQ-011 hi  output  32  Architectural HI register.
REQ-012 lo  output  32  Architectural LO register.
REQ-013 mdOut  output  32  hi when rdSel==1, otherwise lo, purely combinational, for the EX result mux beside the ALU result.

Function
REQ-014 The unit SHALL have the states IDLE, MUL and DIV, and a cycle counter cnt.
REQ-015 In IDLE, start==1 with mult or multu SHALL latch inA/inB, load cnt=MULT_CYCLES and enter MUL at the next edge.
REQ-016 In IDLE, start==1 with div or divu SHALL do the same with cnt=DIV_CYCLES and enter DIV at the next edge.
REQ-017 busy SHALL be registered: high from the edge that accepts start until the edge that commits HI/LO, so it is high for exactly N cycles.
REQ-018 In MUL or DIV, cnt SHALL decrement each cycle; on the edge where cnt reaches 1, the result SHALL be written to HI/LO, busy SHALL drop and the state SHALL return to IDLE.
REQ-019 mult SHALL form the signed 64-bit product of inA and inB: HI gets bits [63:32], LO gets bits [31:0].
REQ-020 multu SHALL form the same split from the unsigned 64-bit product.
REQ-021 div SHALL be signed: LO gets the quotient truncated toward zero, HI gets the remainder with the sign of the dividend.
REQ-022 divu SHALL be unsigned: LO gets the quotient, HI gets the remainder.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no trap.
REQ-024 A divisor of 0 SHALL still run the full DIV_CYCLES with busy high, and SHALL leave HI and LO unchanged.
REQ-025 In IDLE, start==1 with mthi SHALL write inA to HI at the next edge; busy SHALL stay low.
REQ-026 In IDLE, start==1 with mtlo SHALL write inA to LO at the next edge; busy SHALL stay low.
REQ-027 start while busy==1 SHALL be ignored for every mdOp, including mthi and mtlo; the pipeline stalls the issuing instruction.
REQ-028 Operand changes on inA/inB after the accepting edge SHALL NOT affect the result.
REQ-029 hi and lo SHALL hold their old values throughout busy and change only on the commit edge.
REQ-030 On the commit edge with start==1 (busy is still high), the new request SHALL be ignored; a back-to-back op is accepted on the first cycle busy is low.
REQ-031 start with mdOp none or reserved SHALL have no effect.

Reset
REQ-032 While reset==0: hi=0, lo=0, busy=0, state=IDLE, cnt=0, and the latched operands are cleared; this takes effect immediately, without a clock edge.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit.
REQ-034 After reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-035 A shared package mdu_pkg SHALL hold the mdOp encodings, the state encoding, and the default MULT_CYCLES and DIV_CYCLES values.
REQ-036 The decoder/control SHALL import the mdOp encodings from mdu_pkg.
REQ-037 The unit SHALL be a single module with no sub-module; the product and quotient are computed with operators at accept time and held in a pending 64-bit register until commit.

Verification
REQ-038 Mult timing: mult with inA=0xFFFFFFFE (-2), inB=3 -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 multu: inA=0xFFFFFFFF, inB=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 Signed division: div inA=0xFFFFFFF9 (-7), inB=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 Divide by zero: preload with mthi 0x1234, mtlo 0x5678, then divu by 0 -> busy 10 cycles, hi=0x1234 and lo=0x5678 unchanged.
REQ-042 Requests while busy: mtlo 0xAAAA issued during a mult in flight -> ignored; lo equals the product LO after commit.
REQ-043 Reset: assert reset at cycle 3 of a div -> busy=0, hi=lo=0 immediately, no later commit; mdOut follows rdSel in every case.
